// File: rtl/main_mem_ctrl.sv
// Single-port main-memory controller behind the 2-way cache controller.
// Holds each one-word command for LATENCY cycles, then performs it on an internal word array.
module main_mem_ctrl #(
  parameter int AWIDTH   = 9,
  parameter int DWIDTH   = 32,
  parameter int LATENCY  = 4,
  parameter int CNTWIDTH = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [AWIDTH-1:0]   addr_mem,
  input  logic                rd_mem,
  input  logic                wr_mem,
  input  logic [DWIDTH-1:0]   data_mem_out,
  output logic [DWIDTH-1:0]   data_mem_in,
  output logic                ready_mem,
  output logic                protocol_err,
  output logic [CNTWIDTH-1:0] rd_count,
  output logic [CNTWIDTH-1:0] wr_count
);

  if (LATENCY < 1) begin : g_latency_check
    $error("main_mem_ctrl: LATENCY must be at least 1");
  end

  localparam int CW = $clog2(LATENCY) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]        state;
  logic [CW-1:0]     cnt;
  logic              op_wr;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] data_q;
  logic [DWIDTH-1:0] mem [2**AWIDTH];

  logic accept;
  logic complete;
  logic illegal;

  assign accept   = (state == IDLE) && (rd_mem || wr_mem);
  assign complete = (state == BUSY) && (cnt == '0);
  // Both strobes at once, or any strobe while an access is in flight.
  assign illegal  = ((state == IDLE) && rd_mem && wr_mem) ||
                    ((state == BUSY) && (rd_mem || wr_mem));

  // The cache samples this in the same cycle its strobe is visible, so it must drop combinationally.
  assign ready_mem = (state == IDLE) && !rd_mem && !wr_mem;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      op_wr        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      data_mem_in  <= '0;
      protocol_err <= 1'b0;
      rd_count     <= '0;
      wr_count     <= '0;
    end else begin
      if (illegal) protocol_err <= 1'b1;

      if (accept) begin
        addr_q <= addr_mem;
        data_q <= data_mem_out;
        op_wr  <= wr_mem;
        cnt    <= CW'(LATENCY - 1);
        state  <= BUSY;
      end else if (state == BUSY) begin
        if (complete) begin
          state <= IDLE;
          if (op_wr) begin
            if (wr_count != '1) wr_count <= wr_count + CNTWIDTH'(1);
          end else begin
            data_mem_in <= mem[addr_q];
            if (rd_count != '1) rd_count <= rd_count + CNTWIDTH'(1);
          end
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

  // NOTE: the array has no reset; its contents are undefined until written, and a
  // reset mid-access cannot write because complete depends on the reset-cleared state.
  always_ff @(posedge clock) begin
    if (complete && op_wr) mem[addr_q] <= data_q;
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl: one instance at LATENCY=4, one at LATENCY=1.
// Read results are checked through a scoreboard fed from a bench-side memory model.
module tb_main_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [8:0]  addr0, addr1;
  logic        rd0, wr0, rd1, wr1;
  logic [31:0] wd0, wd1;
  logic [31:0] rdat0, rdat1;
  logic        ready0, ready1, err0, err1;
  logic [15:0] rc0, wc0, rc1, wc1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          sel;
    bit          w;
    bit          r;
    logic [8:0]  a;
    logic [31:0] d;
    int          exp_low;
  } vec_t;

  typedef struct {
    bit          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] model [2][512];
  vec_t        vt [5];

  always #5 clock = ~clock;

  main_mem_ctrl #(.AWIDTH(9), .DWIDTH(32), .LATENCY(4), .CNTWIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .addr_mem(addr0), .rd_mem(rd0), .wr_mem(wr0),
    .data_mem_out(wd0), .data_mem_in(rdat0), .ready_mem(ready0), .protocol_err(err0),
    .rd_count(rc0), .wr_count(wc0)
  );

  main_mem_ctrl #(.AWIDTH(9), .DWIDTH(32), .LATENCY(1), .CNTWIDTH(16)) dut1 (
    .clock(clock), .reset_n(reset_n), .addr_mem(addr1), .rd_mem(rd1), .wr_mem(wr1),
    .data_mem_out(wd1), .data_mem_in(rdat1), .ready_mem(ready1), .protocol_err(err1),
    .rd_count(rc1), .wr_count(wc1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit sel, input bit w, input bit r,
                        input logic [8:0] a, input logic [31:0] d);
    if (!sel) begin
      wr0 = w; rd0 = r; addr0 = a; wd0 = d;
    end else begin
      wr1 = w; rd1 = r; addr1 = a; wd1 = d;
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? ready1 : ready0;
  endfunction

  function automatic logic [31:0] get_data(input bit sel);
    return sel ? rdat1 : rdat0;
  endfunction

  // One access: strobe for a cycle, scramble the inputs afterwards, count cycles with ready low.
  task automatic access(input bit sel, input bit w, input bit r, input logic [8:0] a,
                        input logic [31:0] d, input int exp_low, input string name);
    int  low;
    sb_t e;
    @(posedge clock); #1;
    set_in(sel, w, r, a, d);
    if (r && !w) sb.push_back('{sel, model[sel][a]});
    if (w) model[sel][a] = d;
    low = 0;
    @(negedge clock);
    if (!get_ready(sel)) low++;
    @(posedge clock); #1;
    set_in(sel, 1'b0, 1'b0, a ^ 9'h1FF, ~d);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (get_ready(sel)) break;
      low++;
    end
    if (!get_ready(sel)) check({name, "_timeout"}, get_ready(sel), 1);
    check({name, "_low"}, low, exp_low);
    if (r && !w) begin
      e = sb.pop_front();
      check({name, "_rdata"}, get_data(e.sel), e.exp);
    end
  endtask

  initial begin
    logic [15:0] rcb, wcb;

    vt = '{
      '{1'b0, 1'b1, 1'b0, 9'h1A5, 32'hDEADBEEF, 5},
      '{1'b0, 1'b0, 1'b1, 9'h1A5, 32'h00000000, 5},
      '{1'b1, 1'b1, 1'b0, 9'h005, 32'h55AA55AA, 2},
      '{1'b1, 1'b1, 1'b0, 9'h0C2, 32'h11111111, 2},
      '{1'b1, 1'b0, 1'b1, 9'h005, 32'h00000000, 2}
    };

    set_in(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
    set_in(1'b1, 1'b0, 1'b0, 9'h000, 32'h0);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready", ready0, 1);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_ready_after", ready0, 1);
    check("rst_data", rdat0, 32'h0);
    check("rst_err", err0, 0);
    check("rst_rd_count", rc0, 0);
    check("rst_wr_count", wc0, 0);
    check("rst_ready1", ready1, 1);

    for (int i = 0; i < 5; i++)
      access(vt[i].sel, vt[i].w, vt[i].r, vt[i].a, vt[i].d, vt[i].exp_low,
             $sformatf("vec%0d", i));

    // Read data is held through idle cycles and an intervening write.
    repeat (10) @(negedge clock);
    check("hold_idle", rdat0, 32'hDEADBEEF);
    access(1'b0, 1'b1, 1'b0, 9'h003, 32'h0BADF00D, 5, "wr_003");
    check("hold_after_wr", rdat0, 32'hDEADBEEF);
    check("wr_count_2", wc0, 2);
    check("rd_count_1", rc0, 1);
    check("cache_err", err1, 0);
    check("cache_rd_count", rc1, 1);
    check("cache_wr_count", wc1, 2);

    // Read strobe two cycles after accepting a write.
    rcb = rc0; wcb = wc0;
    @(posedge clock); #1;
    set_in(1'b0, 1'b1, 1'b0, 9'h010, 32'h0101F00D);
    model[0][9'h010] = 32'h0101F00D;
    @(posedge clock); #1;
    set_in(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
    @(posedge clock); #1;
    set_in(1'b0, 1'b0, 1'b1, 9'h010, 32'h0);
    @(negedge clock);
    check("busy_strobe_ready", ready0, 0);
    @(posedge clock); #1;
    set_in(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
    @(negedge clock);
    check("busy_e2_ready", ready0, 0);
    @(negedge clock);
    check("busy_e3_ready", ready0, 0);
    @(negedge clock);
    check("busy_e4_ready", ready0, 1);
    check("busy_wr_count", wc0, wcb + 16'd1);
    check("busy_rd_count", rc0, rcb);
    check("busy_err", err0, 1);
    repeat (5) @(negedge clock);
    check("busy_err_sticky", err0, 1);
    check("busy_rd_count_late", rc0, rcb);
    access(1'b0, 1'b0, 1'b1, 9'h010, 32'h0, 5, "busy_verify");

    // Simultaneous strobes: write wins, read dropped.
    rcb = rc1; wcb = wc1;
    access(1'b1, 1'b1, 1'b1, 9'h020, 32'hCAFEF00D, 2, "simul");
    check("simul_wr_count", wc1, wcb + 16'd1);
    check("simul_rd_count", rc1, rcb);
    check("simul_err", err1, 1);
    access(1'b1, 1'b0, 1'b1, 9'h020, 32'h0, 2, "simul_rd");

    // Reset in the middle of a write leaves the old word in place.
    access(1'b0, 1'b1, 1'b0, 9'h030, 32'hA5A5A5A5, 5, "pre_wr");
    @(posedge clock); #1;
    set_in(1'b0, 1'b1, 1'b0, 9'h030, 32'h12345678);
    @(posedge clock); #1;
    set_in(1'b0, 1'b0, 1'b0, 9'h000, 32'h0);
    @(posedge clock);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #2;
    check("midrst_ready", ready0, 1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("midrst_ready_after", ready0, 1);
    check("midrst_err", err0, 0);
    check("midrst_wr_count", wc0, 0);
    access(1'b0, 1'b0, 1'b1, 9'h030, 32'h0, 5, "midrst_rd");

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_mem_ctrl.md
# main_mem_ctrl

Single-port main-memory controller that sits directly downstream of the 2-way set-associative cache controller and serves its memory-side requests. It accepts one-word read and write commands (`rd_mem`/`wr_mem` with `addr_mem`), holds them for a programmable access latency, then performs the access on an internal word array. It signals availability on `ready_mem` and returns read data on a held register. Port names match the cache-side net names so that the two blocks wire together directly.

## Interface
- `AWIDTH`, 9: word address width; the array holds 2^AWIDTH words.
- `DWIDTH`, 32: data word width.
- `LATENCY`, 4: cycles from command acceptance to completion. Legal range ≥1; elaboration fails for 0.
- `CNTWIDTH`, 16: width of the access statistics counters.

Ports:
- `clock`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `addr_mem`  in  AWIDTH  word address of the command.
- `rd_mem`  in  1  read command strobe, active high, one cycle.
- `wr_mem`  in  1  write command strobe, active high, one cycle.
- `data_mem_out`  in  DWIDTH  write data; this is the cache's write-data output.
- `data_mem_in`  out  DWIDTH  read data, registered and held; this is the cache's read-data input.
- `ready_mem`  out  1  controller idle and able to accept a command.
- `protocol_err`  out  1  sticky error flag for an illegal command.
- `rd_count`  out  CNTWIDTH  completed reads, saturating.
- `wr_count`  out  CNTWIDTH  completed writes, saturating.

## Operation
- The FSM has two states, IDLE and BUSY, plus a down-counter `cnt` of width clog2(LATENCY)+1.
- `ready_mem = (state==IDLE) & !rd_mem & !wr_mem`. The path is combinational by design.
  - The cache registers its strobe and then samples `ready_mem` in the same cycle the strobe is visible.
  - `ready_mem` must therefore already be low in that cycle, or the cache treats the access as complete immediately.
- **IDLE, strobe high at an edge (acceptance):**
  - Latch `addr_mem`, latch `data_mem_out`, and latch op = wr if `wr_mem` else rd.
  - Load `cnt` with LATENCY-1 and go to BUSY.
- **BUSY:**
  - If `cnt==0`: perform the access and go to IDLE.
    - Write: array[addr] ← latched data.
    - Read: `data_mem_in` ← array[addr].
  - Otherwise: decrement `cnt`.
- `data_mem_in` changes only on read completion. It holds its value through subsequent writes and idle cycles until the next read completes.
- Counters increment by one on each completion of the matching op and saturate at all-ones.
- Array contents are not cleared by reset and are undefined until written.
- **Boundary conditions:**
  - `rd_mem` and `wr_mem` both high at acceptance: the write is performed, the read is dropped, and `protocol_err` is set.
  - Any strobe high while in BUSY: the strobe is ignored, `protocol_err` is set, and the in-flight access is unaffected.
  - `protocol_err` clears only on reset.
  - `addr_mem` changes after acceptance have no effect.
  - Reset mid-access: the access is abandoned with no array write, and the block returns to IDLE.
  - Counter saturation: a completion at all-ones leaves the count at all-ones.

## Timing
- Reset values:
  - state IDLE, `cnt` 0.
  - `ready_mem` 1 whenever both strobes are low.
  - `data_mem_in` 0, `protocol_err` 0, `rd_count` 0, `wr_count` 0.
- Accept edge E0:
  - `ready_mem` is low in the cycle the strobe is high, and stays low after E0 until the completion edge.
  - The access is performed at edge E0+LATENCY.
  - `ready_mem` is high and `data_mem_in` is valid from E0+LATENCY.
  - `data_mem_in` remains valid at least until the next read completes.
- Throughput: the earliest next acceptance is edge E0+LATENCY+1, because a strobe requires a registered response from the cache.
- With LATENCY=1, `ready_mem` is low for 2 cycles per access: the strobe cycle plus one BUSY cycle.
- The cache's write-back-then-fill sequence (write, wait for ready, read, wait for ready) needs no idle cycles inserted by this block.

## Test plan
- **Reset:** assert `reset_n`=0 for 3 cycles with strobes low.
  - Required: `ready_mem`=1, `data_mem_in`=0, `protocol_err`=0, both counters 0.
- **Write then read, LATENCY=4:** write 0xDEADBEEF to address 0x1A5, wait for ready, then read 0x1A5.
  - Required: `ready_mem` low for exactly 5 cycles per access.
  - Required: `data_mem_in`=0xDEADBEEF at E0+4 of the read, still held 10 cycles later and after an intervening write to 0x003.
  - Required: `wr_count`=2, `rd_count`=1.
- **Cache-style write-back then fill, LATENCY=1:**
  - Stimulus: write 0x11111111 to 0x0C2, then read 0x005 (previously written 0x55AA55AA). Each strobe is issued in the cycle after `ready_mem` is seen high.
  - Required: read returns 0x55AA55AA, `protocol_err`=0.
- **Strobe during BUSY:** pulse `rd_mem` to 0x010 two cycles after accepting a write to 0x010.
  - Required: the write completes at E0+LATENCY, no extra read completes, `rd_count` unchanged, `protocol_err`=1 and it stays 1.
- **Simultaneous strobes:** `rd_mem`=`wr_mem`=1 at 0x020 with data 0xCAFEF00D.
  - Required: array[0x020]=0xCAFEF00D (verified by a later read), `wr_count`+1, `rd_count`+0, `protocol_err`=1.
- **Reset mid-access:** accept a write of 0x12345678 to 0x030 (old value 0xA5A5A5A5), then assert reset at E0+2 with LATENCY=4.
  - Required: `ready_mem`=1 immediately after reset, and a subsequent read of 0x030 returns 0xA5A5A5A5.
